// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money width, coin denominations,
// prices and the change dispenser state encoding.
package vm_pkg;
    localparam int MONEY_W   = 8;
    localparam int NUM_DENOM = 4;

    localparam logic [MONEY_W-1:0] COIN_1  = 8'd1;
    localparam logic [MONEY_W-1:0] COIN_5  = 8'd5;
    localparam logic [MONEY_W-1:0] COIN_10 = 8'd10;
    localparam logic [MONEY_W-1:0] COIN_50 = 8'd50;

    // Inventory slot of each denomination, largest first
    localparam logic [1:0] IDX_50 = 2'd0;
    localparam logic [1:0] IDX_10 = 2'd1;
    localparam logic [1:0] IDX_5  = 2'd2;
    localparam logic [1:0] IDX_1  = 2'd3;

    // Product prices used by the vending controller
    localparam logic [MONEY_W-1:0] PRICE_WATER = 8'd65;
    localparam logic [MONEY_W-1:0] PRICE_SODA  = 8'd85;
    localparam logic [MONEY_W-1:0] PRICE_SNACK = 8'd120;

    typedef enum logic [1:0] {
        DISP_IDLE,
        DISP_SELECT,
        DISP_ISSUE,
        DISP_DONE
    } disp_state_t;

    // Map a coin value to its inventory slot
    function automatic logic [1:0] coin_idx(input logic [MONEY_W-1:0] coin);
        case (coin)
            COIN_50: return IDX_50;
            COIN_10: return IDX_10;
            COIN_5:  return IDX_5;
            default: return IDX_1;
        endcase
    endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// Request / coin-out / status bundle between the dispenser and its users.
interface change_dispenser_if;
    import vm_pkg::*;

    logic               change_valid;
    logic [MONEY_W-1:0] change_amount;
    logic               change_ready;
    logic               coin_valid;
    logic [MONEY_W-1:0] coin_out;
    logic               coin_ack;
    logic               refill;
    logic               done;
    logic [MONEY_W-1:0] shortfall;
    logic               busy;

    // Dispenser side
    modport slave (
        input  change_valid, change_amount, coin_ack, refill,
        output change_ready, coin_valid, coin_out, done, shortfall, busy
    );

    // Controller / hopper side
    modport master (
        output change_valid, change_amount, coin_ack, refill,
        input  change_ready, coin_valid, coin_out, done, shortfall, busy
    );
endinterface

// File: rtl/change_coin_select.sv
// Greedy picker: largest denomination that fits the remaining amount and
// still has coins in stock.
module change_coin_select
    import vm_pkg::*;
(
    input  logic [MONEY_W-1:0]   remaining,
    input  logic [NUM_DENOM-1:0] avail,
    output logic [MONEY_W-1:0]   coin,
    output logic                 found
);
    // Priority chain, largest first
    always_comb begin
        coin  = '0;
        found = 1'b1;
        if (avail[IDX_50] && remaining >= COIN_50)      coin = COIN_50;
        else if (avail[IDX_10] && remaining >= COIN_10) coin = COIN_10;
        else if (avail[IDX_5] && remaining >= COIN_5)   coin = COIN_5;
        else if (avail[IDX_1] && remaining >= COIN_1)   coin = COIN_1;
        else                                            found = 1'b0;
    end
endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a change amount out one coin at a time, greedy
// largest-first, tracking per-denomination inventory and reporting any
// unpaid remainder.
module change_dispenser
    import vm_pkg::*;
#(
    parameter logic [MONEY_W-1:0] INV_INIT = 8'd20
) (
    input logic              clk,
    input logic              reset,
    change_dispenser_if.slave bus
);
    disp_state_t state, state_nx;
    logic [MONEY_W-1:0] remaining, remaining_nx;
    logic [MONEY_W-1:0] coin, coin_nx;
    logic [MONEY_W-1:0] shortfall, shortfall_nx;
    logic [NUM_DENOM-1:0][MONEY_W-1:0] inv, inv_nx;
    logic [NUM_DENOM-1:0] avail;
    logic [MONEY_W-1:0] sel_coin;
    logic               sel_found;
    logic               ready, coin_valid, done, busy;
    logic [1:0]         ack_idx;

    // Stock flags for the picker
    always_comb begin
        for (int i = 0; i < NUM_DENOM; i++) avail[i] = (inv[i] != '0);
    end

    change_coin_select u_select (
        .remaining (remaining),
        .avail     (avail),
        .coin      (sel_coin),
        .found     (sel_found)
    );

    // Next-state and datapath updates
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        coin_nx      = coin;
        shortfall_nx = shortfall;
        inv_nx       = inv;
        ack_idx      = coin_idx(coin);
        unique case (state)
            DISP_IDLE: begin
                if (bus.change_valid && ready) begin
                    remaining_nx = bus.change_amount;
                    shortfall_nx = '0;
                    state_nx     = DISP_SELECT;
                end else if (bus.refill) begin
                    inv_nx = {NUM_DENOM{INV_INIT}};
                end
            end
            DISP_SELECT: begin
                if (sel_found) begin
                    coin_nx  = sel_coin;
                    state_nx = DISP_ISSUE;
                end else begin
                    shortfall_nx = remaining;
                    state_nx     = DISP_DONE;
                end
            end
            DISP_ISSUE: begin
                if (bus.coin_ack) begin
                    // The picker only offers coins that fit and are in stock
                    remaining_nx = remaining - coin;
                    if (inv[ack_idx] != '0) inv_nx[ack_idx] = inv[ack_idx] - 8'd1;
                    coin_nx  = '0;
                    state_nx = DISP_SELECT;
                end
            end
            DISP_DONE: state_nx = DISP_IDLE;
            default:   state_nx = DISP_IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DISP_IDLE;
            remaining  <= '0;
            coin       <= '0;
            shortfall  <= '0;
            inv        <= {NUM_DENOM{INV_INIT}};
            ready      <= 1'b0;
            coin_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            coin       <= coin_nx;
            shortfall  <= shortfall_nx;
            inv        <= inv_nx;
            ready      <= (state_nx == DISP_IDLE);
            coin_valid <= (state_nx == DISP_ISSUE);
            done       <= (state_nx == DISP_DONE);
            busy       <= (state_nx != DISP_IDLE);
        end
    end

    assign bus.change_ready = ready;
    assign bus.coin_valid   = coin_valid;
    assign bus.coin_out     = coin;
    assign bus.done         = done;
    assign bus.shortfall    = shortfall;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (stock 20 and stock 2) driven by
// directed steps; a scoreboard holds expected coins and shortfalls.
module tb_change_dispenser;
    import vm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    change_dispenser_if bus_a ();
    change_dispenser_if bus_b ();

    change_dispenser #(.INV_INIT(8'd20)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    change_dispenser #(.INV_INIT(8'd2))  dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_coin_a[$], exp_coin_b[$], exp_short_a[$], exp_short_b[$];
    int done_a = 0, done_b = 0, want_a = 0, want_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard for instance A: coins taken on ack, shortfall on done
    always @(negedge clk) begin
        if (bus_a.coin_valid === 1'b1 && bus_a.coin_ack === 1'b1) begin
            if (exp_coin_a.size() == 0) check("a_unexpected_coin", exp_coin_a.size(), 1);
            else check("a_coin", bus_a.coin_out, exp_coin_a.pop_front());
        end
        if (bus_a.done === 1'b1) begin
            if (exp_short_a.size() == 0) check("a_unexpected_done", exp_short_a.size(), 1);
            else begin
                check("a_shortfall", bus_a.shortfall, exp_short_a.pop_front());
                check("a_coins_missing", exp_coin_a.size(), 0);
            end
            done_a++;
        end
    end

    // Scoreboard for instance B
    always @(negedge clk) begin
        if (bus_b.coin_valid === 1'b1 && bus_b.coin_ack === 1'b1) begin
            if (exp_coin_b.size() == 0) check("b_unexpected_coin", exp_coin_b.size(), 1);
            else check("b_coin", bus_b.coin_out, exp_coin_b.pop_front());
        end
        if (bus_b.done === 1'b1) begin
            if (exp_short_b.size() == 0) check("b_unexpected_done", exp_short_b.size(), 1);
            else begin
                check("b_shortfall", bus_b.shortfall, exp_short_b.pop_front());
                check("b_coins_missing", exp_coin_b.size(), 0);
            end
            done_b++;
        end
    end

    task automatic request(input bit b, input logic [7:0] amt);
        int n = 0;
        @(negedge clk);
        if (b) begin bus_b.change_valid = 1'b1; bus_b.change_amount = amt; end
        else   begin bus_a.change_valid = 1'b1; bus_a.change_amount = amt; end
        while (!(b ? bus_b.change_ready : bus_a.change_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_in_time", (n < 50), 1);
        @(negedge clk);
        bus_a.change_valid = 1'b0;
        bus_b.change_valid = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int target);
        int n = 0;
        while ((b ? done_b : done_a) < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(b ? "b_done_count" : "a_done_count", b ? done_b : done_a, target);
    endtask

    task automatic push_a(input logic [7:0] c); exp_coin_a.push_back(c); endtask
    task automatic push_b(input logic [7:0] c); exp_coin_b.push_back(c); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus_a.change_valid = 0; bus_a.change_amount = 0; bus_a.coin_ack = 1; bus_a.refill = 0;
        bus_b.change_valid = 0; bus_b.change_amount = 0; bus_b.coin_ack = 1; bus_b.refill = 0;
        reset = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready",      bus_a.change_ready, 0);
        check("rst_coin_valid", bus_a.coin_valid, 0);
        check("rst_coin_out",   bus_a.coin_out, 0);
        check("rst_done",       bus_a.done, 0);
        check("rst_shortfall",  bus_a.shortfall, 0);
        check("rst_busy",       bus_a.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus_a.change_ready, 1);

        // 37 with full stock
        push_a(10); push_a(10); push_a(10); push_a(5); push_a(1); push_a(1);
        exp_short_a.push_back(0);
        request(0, 8'd37);
        want_a++; wait_done(0, want_a);
        check("inv50_after_37", dut_a.inv[IDX_50], 20);
        check("inv10_after_37", dut_a.inv[IDX_10], 17);
        check("inv5_after_37",  dut_a.inv[IDX_5], 19);
        check("inv1_after_37",  dut_a.inv[IDX_1], 18);

        // 88, then refill in IDLE
        push_a(50); push_a(10); push_a(10); push_a(10); push_a(5); push_a(1); push_a(1); push_a(1);
        exp_short_a.push_back(0);
        request(0, 8'd88);
        want_a++; wait_done(0, want_a);
        check("inv10_after_88", dut_a.inv[IDX_10], 14);
        check("inv1_after_88",  dut_a.inv[IDX_1], 15);
        @(negedge clk);
        bus_a.refill = 1'b1;
        @(negedge clk);
        bus_a.refill = 1'b0;
        for (int i = 0; i < NUM_DENOM; i++) check("inv_after_refill", dut_a.inv[i], 20);

        // Stock of 2: 37 runs short, then 3 cannot be paid at all
        push_b(10); push_b(10); push_b(5); push_b(5); push_b(1); push_b(1);
        exp_short_b.push_back(5);
        request(1, 8'd37);
        want_b++; wait_done(1, want_b);
        exp_short_b.push_back(3);
        request(1, 8'd3);
        want_b++; wait_done(1, want_b);

        // Zero amount: accept, SELECT, DONE, IDLE
        exp_short_a.push_back(0);
        @(negedge clk);
        check("zero_ready", bus_a.change_ready, 1);
        bus_a.change_valid = 1'b1; bus_a.change_amount = 8'd0;
        @(negedge clk);
        bus_a.change_valid = 1'b0;
        check("zero_busy_select", bus_a.busy, 1);
        check("zero_no_done_yet", bus_a.done, 0);
        @(negedge clk);
        check("zero_done",      bus_a.done, 1);
        check("zero_shortfall", bus_a.shortfall, 0);
        check("zero_no_coin",   bus_a.coin_valid, 0);
        @(negedge clk);
        check("zero_done_cleared", bus_a.done, 0);
        check("zero_back_idle",    bus_a.change_ready, 1);
        want_a++; wait_done(0, want_a);

        // Backpressure on the first coin of 6; a request while busy is dropped
        push_a(5); push_a(1);
        exp_short_a.push_back(0);
        @(negedge clk);
        bus_a.coin_ack = 1'b0;
        bus_a.change_valid = 1'b1; bus_a.change_amount = 8'd6;
        @(negedge clk);
        bus_a.change_valid = 1'b0;
        check("bp_busy", bus_a.busy, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_coin_valid_held", bus_a.coin_valid, 1);
            check("bp_coin_out_held",   bus_a.coin_out, 5);
            bus_a.change_valid = (i == 0);
            bus_a.change_amount = 8'd50;
        end
        bus_a.change_valid = 1'b0;
        bus_a.coin_ack = 1'b1;
        want_a++; wait_done(0, want_a);
        repeat (4) @(negedge clk);
        check("bp_no_extra_done", done_a, want_a);

        // Reset during ISSUE of the second coin of 37
        push_a(10);
        @(negedge clk);
        bus_a.change_valid = 1'b1; bus_a.change_amount = 8'd37;
        @(negedge clk);
        bus_a.change_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_a.coin_ack = 1'b0;
        @(negedge clk);
        check("rst_mid_issue_valid", bus_a.coin_valid, 1);
        check("rst_mid_issue_coin",  bus_a.coin_out, 10);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_coin_valid", bus_a.coin_valid, 0);
        check("rst_mid_busy",       bus_a.busy, 0);
        check("rst_mid_done",       bus_a.done, 0);
        check("rst_mid_inv10",      dut_a.inv[IDX_10], 20);
        check("rst_mid_coins_left", exp_coin_a.size(), 0);
        reset = 1'b0;
        bus_a.coin_ack = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", bus_a.change_ready, 1);
        check("rst_mid_no_done", done_a, want_a);

        push_a(10); push_a(5);
        exp_short_a.push_back(0);
        request(0, 8'd15);
        want_a++; wait_done(0, want_a);
        repeat (3) @(negedge clk);
        check("final_coin_queue_a",  exp_coin_a.size(), 0);
        check("final_short_queue_a", exp_short_a.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
